iir_biquad_tdm: RTL

Time-multiplexed, parametrised cascade of IIR biquad sections serving `N_CH` audio channels with one shared multiply-accumulate unit. It is the multi-channel, multi-stage successor of the single-section mono biquad core and sits between the audio input stream and the output formatter. Each channel and each stage keeps its own state. Coefficients are per stage and shared across channels. They are double-buffered so they can be updated glitch-free at run time.

---
 rtl/iir_tdm_pkg.sv | 36 +++
 rtl/iir_coef_bank.sv | 46 ++++
 rtl/iir_biquad_tdm.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/iir_tdm_pkg.sv
// Shared types and helpers for the time-multiplexed biquad cascade.
// FSM states, coefficient slot indices and output saturation.
package iir_tdm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MAC,
      ST_WB,
      ST_OUT
   } state_t;

   localparam int K_B0   = 0;
   localparam int K_B1   = 1;
   localparam int K_B2   = 2;
   localparam int K_A1   = 3;
   localparam int K_A2   = 4;
   localparam int N_COEF = 5;

   // Arithmetic right shift, then clamp to a signed w-bit range.
   function automatic logic signed [63:0] sat_shift(
      input logic signed [63:0] v,
      input int                 sh,
      input int                 w
   );
      logic signed [63:0] s;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      s  = v >>> sh;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (s > hi) return hi;
      if (s < lo) return lo;
      return s;
   endfunction

endpackage

// File: rtl/iir_coef_bank.sv
// Double-buffered coefficient store: shadow written at any time,
// active bank refreshed only on a commit strobe.
module iir_coef_bank
   import iir_tdm_pkg::*;
#(
   parameter int COEF_W    = 18,
   parameter int COEF_FRAC = 14,
   parameter int N_STAGES  = 2,
   parameter int ADDR_W    = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic [ADDR_W-1:0]        addr,
   input  logic signed [COEF_W-1:0] wdata,
   input  logic                     commit,
   input  logic [ADDR_W-1:0]        rd_addr,
   output logic signed [COEF_W-1:0] rd_coef
);

   localparam int N_ENT = N_STAGES * N_COEF;
   localparam logic signed [COEF_W-1:0] UNITY = COEF_W'(1 << COEF_FRAC);

   logic signed [COEF_W-1:0] shadow [N_ENT];
   logic signed [COEF_W-1:0] active [N_ENT];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_ENT; i++) begin
            shadow[i] <= (i % N_COEF == K_B0) ? UNITY : '0;
            active[i] <= (i % N_COEF == K_B0) ? UNITY : '0;
         end
      end else begin
         for (int i = 0; i < N_ENT; i++) begin
            if (we && int'(addr) == i)
               shadow[i] <= wdata;
            // a write in the copy cycle is forwarded into the active bank
            if (commit)
               active[i] <= (we && int'(addr) == i) ? wdata : shadow[i];
         end
      end
   end

   assign rd_coef = active[rd_addr];

endmodule

// File: rtl/iir_biquad_tdm.sv
// Multi-channel cascade of biquad sections sharing one multiplier.
// Each sample walks every stage: 5 MAC cycles plus 1 write-back.
module iir_biquad_tdm
   import iir_tdm_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int COEF_W     = 18,
   parameter int COEF_FRAC  = 14,
   parameter int ACC_W      = 48,
   parameter int N_CH       = 2,
   parameter int N_STAGES   = 2,
   parameter int DAMP_SHIFT = 10,
   localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1,
   localparam int CFG_AW = $clog2(N_STAGES * 5)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic [CH_W-1:0]   s_ch,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic [CH_W-1:0]   m_ch,
   input  logic              cfg_we,
   input  logic [CFG_AW-1:0] cfg_addr,
   input  logic [COEF_W-1:0] cfg_data,
   input  logic              cfg_commit,
   input  logic              clr,
   output logic              busy
);

   localparam int SG_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
   localparam int P_W  = COEF_W + DATA_W;

   state_t state, state_nx;

   logic [SG_W-1:0]          stage;
   logic [2:0]               k;
   logic [CH_W-1:0]          ch;
   logic signed [DATA_W-1:0] x_cur;
   logic signed [ACC_W-1:0]  acc;
   logic                     commit_pend;
   logic                     clr_pend;

   logic signed [DATA_W-1:0] x1 [N_CH][N_STAGES];
   logic signed [DATA_W-1:0] x2 [N_CH][N_STAGES];
   logic signed [DATA_W-1:0] y1 [N_CH][N_STAGES];
   logic signed [DATA_W-1:0] y2 [N_CH][N_STAGES];

   logic                     svc;
   logic                     take;
   logic                     ch_ok;
   logic                     last_stage;
   logic [CFG_AW-1:0]        rd_addr;
   logic signed [COEF_W-1:0] coef;
   logic signed [DATA_W-1:0] dsel;
   logic                     neg;
   logic signed [P_W-1:0]    prod;
   logic signed [ACC_W-1:0]  prod_ext;
   logic signed [ACC_W-1:0]  acc_nx;
   logic signed [63:0]       sat_v;
   logic signed [DATA_W-1:0] y;
   logic signed [DATA_W-1:0] y_damp;

   assign svc        = (state == ST_IDLE) && (commit_pend || clr_pend);
   assign s_ready    = (state == ST_IDLE) && !svc;
   assign take       = s_valid && s_ready;
   assign ch_ok      = int'(s_ch) < N_CH;
   assign last_stage = int'(stage) == N_STAGES - 1;
   assign m_valid    = state == ST_OUT;
   assign busy       = state != ST_IDLE;

   assign rd_addr = CFG_AW'(int'(stage) * N_COEF + int'(k));

   iir_coef_bank #(
      .COEF_W    (COEF_W),
      .COEF_FRAC (COEF_FRAC),
      .N_STAGES  (N_STAGES),
      .ADDR_W    (CFG_AW)
   ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .we      (cfg_we),
      .addr    (cfg_addr),
      .wdata   (cfg_data),
      .commit  (svc && commit_pend),
      .rd_addr (rd_addr),
      .rd_coef (coef)
   );

   always_comb begin
      dsel = x_cur;
      neg  = 1'b0;
      case (k)
         3'd1: dsel = x1[ch][stage];
         3'd2: dsel = x2[ch][stage];
         3'd3: begin dsel = y1[ch][stage]; neg = 1'b1; end
         3'd4: begin dsel = y2[ch][stage]; neg = 1'b1; end
         default: dsel = x_cur;
      endcase
   end

   assign prod     = P_W'(coef) * P_W'(dsel);
   assign prod_ext = ACC_W'(prod);
   assign acc_nx   = ((k == 3'd0) ? '0 : acc)
                   + (neg ? -prod_ext : prod_ext);

   assign sat_v  = sat_shift(64'(acc), COEF_FRAC, DATA_W);
   assign y      = sat_v[DATA_W-1:0];
   assign y_damp = (DAMP_SHIFT == 0) ? y : y - (y >>> DAMP_SHIFT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE: if (take && ch_ok) state_nx = ST_MAC;
         ST_MAC:  if (k == 3'd4) state_nx = ST_WB;
         ST_WB:   state_nx = last_stage ? ST_OUT : ST_MAC;
         ST_OUT:  if (m_ready) state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage       <= '0;
         k           <= '0;
         ch          <= '0;
         x_cur       <= '0;
         acc         <= '0;
         m_data      <= '0;
         m_ch        <= '0;
         commit_pend <= 1'b0;
         clr_pend    <= 1'b0;
         for (int c = 0; c < N_CH; c++)
            for (int s = 0; s < N_STAGES; s++) begin
               x1[c][s] <= '0;
               x2[c][s] <= '0;
               y1[c][s] <= '0;
               y2[c][s] <= '0;
            end
      end else begin
         commit_pend <= cfg_commit || (commit_pend && !svc);
         clr_pend    <= clr || (clr_pend && !svc);
         case (state)
            ST_IDLE: begin
               if (svc) begin
                  if (clr_pend)
                     for (int c = 0; c < N_CH; c++)
                        for (int s = 0; s < N_STAGES; s++) begin
                           x1[c][s] <= '0;
                           x2[c][s] <= '0;
                           y1[c][s] <= '0;
                           y2[c][s] <= '0;
                        end
               end else if (take) begin
                  x_cur <= s_data;
                  ch    <= s_ch;
                  stage <= '0;
                  k     <= '0;
               end
            end
            ST_MAC: begin
               acc <= acc_nx;
               k   <= k + 3'd1;
            end
            ST_WB: begin
               x2[ch][stage] <= x1[ch][stage];
               x1[ch][stage] <= x_cur;
               y2[ch][stage] <= y1[ch][stage];
               y1[ch][stage] <= y_damp;
               x_cur         <= y;
               k             <= '0;
               if (last_stage) begin
                  m_data <= y;
                  m_ch   <= ch;
               end else begin
                  stage <= stage + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
